// File: rtl/dft_frame_sequencer.sv
// Frame sequencer for the windowed-DFT accumulator: arms the accumulator, streams N
// window-aligned I/Q samples, waits for completion and hands the result downstream.
module dft_frame_sequencer #(
    parameter int IQ_WIDTH           = 16,
    parameter int WINDOW_WIDTH       = 18,
    parameter int SAMPLE_COUNT_WIDTH = 16,
    parameter int FRAME_ID_WIDTH     = 8,
    parameter int DONE_TIMEOUT       = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [SAMPLE_COUNT_WIDTH-1:0]  frame_len_i,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
    input  logic signed [IQ_WIDTH-1:0]     s_i_i,
    input  logic signed [IQ_WIDTH-1:0]     s_q_i,
    output logic [SAMPLE_COUNT_WIDTH-1:0]  win_addr_o,
    input  logic signed [WINDOW_WIDTH-1:0] win_coeff_i,
    output logic                           acc_start_o,
    output logic                           acc_sample_valid_o,
    output logic                           acc_last_sample_o,
    output logic signed [IQ_WIDTH-1:0]     acc_i_o,
    output logic signed [IQ_WIDTH-1:0]     acc_q_o,
    output logic signed [WINDOW_WIDTH-1:0] acc_window_o,
    input  logic                           acc_busy_i,
    input  logic                           acc_valid_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [FRAME_ID_WIDTH-1:0]      frame_id_o,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int WD_WIDTH = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_STREAM,
        S_WAIT_DONE,
        S_HOLD
    } state_t;

    state_t                          state, state_nxt;
    logic [SAMPLE_COUNT_WIDTH-1:0]   frame_len;
    logic [SAMPLE_COUNT_WIDTH-1:0]   cnt;
    logic [WD_WIDTH-1:0]             wd_cnt;
    logic                            strobe;
    logic                            strobe_last;
    logic signed [IQ_WIDTH-1:0]      samp_i, samp_q;
    logic signed [WINDOW_WIDTH-1:0]  win_hold;
    logic [FRAME_ID_WIDTH-1:0]       frame_id;
    logic                            err;
    logic                            accept;
    logic                            wd_expired;

    assign accept     = s_valid_i & s_ready_o;
    assign wd_expired = (wd_cnt == WD_WIDTH'(DONE_TIMEOUT - 1));

    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        s_ready_o   = 1'b0;
        win_addr_o  = '0;
        acc_start_o = 1'b0;
        res_valid_o = 1'b0;
        busy_o      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start_i && !acc_busy_i && (frame_len_i != '0))
                    state_nxt = S_ARM;
            end
            S_ARM: begin
                acc_start_o = 1'b1;
                state_nxt   = S_STREAM;
            end
            S_STREAM: begin
                s_ready_o  = (cnt < frame_len);
                win_addr_o = cnt;
                if (strobe_last)
                    state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (acc_valid_i)
                    state_nxt = S_HOLD;
                else if (wd_expired)
                    state_nxt = S_IDLE;
            end
            S_HOLD: begin
                res_valid_o = 1'b1;
                if (res_ready_i)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            frame_len   <= '0;
            cnt         <= '0;
            wd_cnt      <= '0;
            strobe      <= 1'b0;
            strobe_last <= 1'b0;
            samp_i      <= '0;
            samp_q      <= '0;
            win_hold    <= '0;
            frame_id    <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            strobe      <= accept;
            strobe_last <= accept && (cnt == frame_len - SAMPLE_COUNT_WIDTH'(1));

            if (accept) begin
                samp_i <= s_i_i;
                samp_q <= s_q_i;
                cnt    <= cnt + SAMPLE_COUNT_WIDTH'(1);
            end

            // Registered ROM data is only valid in the strobe cycle; keep it afterwards.
            if (strobe)
                win_hold <= win_coeff_i;

            if (state == S_IDLE && start_i) begin
                if (frame_len_i == '0) begin
                    err <= 1'b1;
                end else if (!acc_busy_i) begin
                    frame_len <= frame_len_i;
                    cnt       <= '0;
                end
            end

            if (state == S_WAIT_DONE) begin
                wd_cnt <= wd_cnt + WD_WIDTH'(1);
                if (!acc_valid_i && wd_expired)
                    err <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end

            if (state == S_HOLD && res_ready_i)
                frame_id <= frame_id + FRAME_ID_WIDTH'(1);
        end
    end

    assign acc_sample_valid_o = strobe;
    assign acc_last_sample_o  = strobe & strobe_last;
    assign acc_i_o            = samp_i;
    assign acc_q_o            = samp_q;
    assign acc_window_o       = strobe ? win_coeff_i : win_hold;
    assign frame_id_o         = frame_id;
    assign err_o              = err;

endmodule

// File: tb/tb_dft_frame_sequencer.sv
// Scoreboard bench for dft_frame_sequencer: the driver queues each expected accumulator
// strobe on acceptance, a negedge monitor pops and compares whenever a strobe appears.
module tb_dft_frame_sequencer;

    localparam int IQW = 16;
    localparam int WW  = 18;
    localparam int SCW = 16;
    localparam int FIW = 8;
    localparam int TO  = 64;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [SCW-1:0]        frame_len = '0;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic signed [IQW-1:0] s_i = '0, s_q = '0;
    logic [SCW-1:0]        win_addr;
    logic signed [WW-1:0]  win_coeff;
    logic                  acc_start, acc_sv, acc_last;
    logic signed [IQW-1:0] acc_i, acc_q;
    logic signed [WW-1:0]  acc_window;
    logic                  acc_busy = 1'b0;
    logic                  acc_valid = 1'b0;
    logic                  res_valid;
    logic                  res_ready = 1'b0;
    logic [FIW-1:0]        frame_id;
    logic                  busy, err;

    dft_frame_sequencer #(
        .IQ_WIDTH(IQW), .WINDOW_WIDTH(WW), .SAMPLE_COUNT_WIDTH(SCW),
        .FRAME_ID_WIDTH(FIW), .DONE_TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .frame_len_i(frame_len),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_i_i(s_i), .s_q_i(s_q),
        .win_addr_o(win_addr), .win_coeff_i(win_coeff),
        .acc_start_o(acc_start), .acc_sample_valid_o(acc_sv), .acc_last_sample_o(acc_last),
        .acc_i_o(acc_i), .acc_q_o(acc_q), .acc_window_o(acc_window),
        .acc_busy_i(acc_busy), .acc_valid_i(acc_valid),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .frame_id_o(frame_id), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    // Registered window ROM, one cycle latency, contents 100+addr.
    always @(posedge clk) win_coeff <= WW'(100 + int'(win_addr));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [IQW-1:0] i;
        logic [IQW-1:0] q;
        logic [WW-1:0]  win;
        logic           last;
    } strobe_t;

    strobe_t exp_q[$];
    int      exp_cyc_q[$];

    logic [IQW-1:0] i_tab [8] = '{16'h0010, 16'hFFF0, 16'h7FFF, 16'h8000,
                                  16'h1234, 16'hEDCB, 16'h0001, 16'hFFFF};
    logic [IQW-1:0] q_tab [8] = '{16'h0020, 16'h8001, 16'h0000, 16'h7FFE,
                                  16'hABCD, 16'h5432, 16'hFFFE, 16'h0002};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int      start_cnt = 0;
    int      ready_cnt = 0;
    int      resv_cnt  = 0;
    strobe_t mon_exp;
    int      mon_cyc;

    always @(negedge clk) begin
        if (acc_start === 1'b1) start_cnt++;
        if (s_ready === 1'b1)   ready_cnt++;
        if (res_valid === 1'b1) resv_cnt++;
        if (acc_last === 1'b1 && acc_sv !== 1'b1)
            check("last_without_strobe", 64'(acc_sv), 64'd1);
        if (acc_sv === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                check("strobe_data", 64'({acc_i, acc_q, acc_window, acc_last}), 64'(mon_exp));
                check("strobe_cycle", 64'(cyc), 64'(mon_cyc));
            end
        end
    end

    task automatic start_frame(input int n);
        frame_len = SCW'(n);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // mode 0: s_valid always high; mode 1: toggles 1,0,1,0. Stops after stop_at accepts.
    task automatic stream(input int n, input int mode, input int stop_at);
        int      k   = 0;
        int      idx = 0;
        strobe_t e;
        while (idx < stop_at && k < 64) begin
            s_valid = (mode == 0) || (k % 2 == 0);
            s_i     = i_tab[idx];
            s_q     = q_tab[idx];
            if (s_valid && s_ready) begin
                e.i    = i_tab[idx];
                e.q    = q_tab[idx];
                e.win  = WW'(100 + idx);
                e.last = (idx == n - 1);
                exp_q.push_back(e);
                exp_cyc_q.push_back(cyc + 1);
                idx++;
            end
            @(negedge clk);
            k++;
        end
        s_valid = 1'b0;
        if (idx < stop_at) check("stream_accept_count", 64'(idx), 64'(stop_at));
    endtask

    // Returns on the negedge one cycle after the last expected strobe was seen.
    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(posedge clk);
            g++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    logic [FIW-1:0] exp_fid = '0;

    task automatic complete(input int delay);
        repeat (delay - 1) @(negedge clk);
        acc_valid = 1'b1;
        @(negedge clk);
        acc_valid = 1'b0;
        check("res_valid_after_done", 64'(res_valid), 64'd1);
        check("frame_id_held", 64'(frame_id), 64'(exp_fid));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_fid++;
        check("frame_id_after_handshake", 64'(frame_id), 64'(exp_fid));
        check("res_valid_cleared", 64'(res_valid), 64'd0);
    endtask

    int s0, r0, v0;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_ctrl", 64'({s_ready, acc_start, acc_sv, acc_last, res_valid, busy, err,
                                 frame_id, win_addr}), 64'd0);
        check("reset_data", 64'({acc_i, acc_q, acc_window}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // N=4, continuous valid
        s0 = start_cnt; r0 = ready_cnt;
        start_frame(4);
        stream(4, 0, 4);
        wait_drain();
        check("n4_start_pulses", 64'(start_cnt - s0), 64'd1);
        check("n4_ready_cycles", 64'(ready_cnt - r0), 64'd4);
        check("n4_busy_waiting", 64'(busy), 64'd1);
        complete(2);

        // N=8, toggling valid
        s0 = start_cnt;
        start_frame(8);
        stream(8, 1, 8);
        wait_drain();
        check("n8_start_pulses", 64'(start_cnt - s0), 64'd1);
        complete(1);

        // N=1 with a held result and start during the handshake
        start_frame(1);
        stream(1, 0, 1);
        wait_drain();
        repeat (2) @(negedge clk);
        acc_valid = 1'b1;
        @(negedge clk);
        acc_valid = 1'b0;
        check("n1_res_valid", 64'(res_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("n1_res_valid_held", 64'(res_valid), 64'd1);
        end
        res_ready = 1'b1;
        start     = 1'b1;
        frame_len = SCW'(1);
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        exp_fid++;
        check("n1_frame_id", 64'(frame_id), 64'(exp_fid));
        check("start_in_handshake_ignored", 64'(busy), 64'd0);

        // acc_valid_i while idle
        acc_valid = 1'b1;
        @(negedge clk);
        acc_valid = 1'b0;
        check("idle_acc_valid_busy", 64'(busy), 64'd0);
        check("idle_acc_valid_res", 64'(res_valid), 64'd0);

        // start while accumulator busy
        s0 = start_cnt;
        acc_busy  = 1'b1;
        frame_len = SCW'(4);
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        acc_busy = 1'b0;
        check("busy_start_ignored", 64'(busy), 64'd0);
        @(negedge clk);
        check("busy_start_no_pulse", 64'(start_cnt - s0), 64'd0);

        // done timeout
        v0 = resv_cnt;
        start_frame(2);
        stream(2, 0, 2);
        wait_drain();
        repeat (TO - 1) @(negedge clk);
        check("timeout_last_wait_cycle_busy", 64'(busy), 64'd1);
        check("timeout_err_not_yet", 64'(err), 64'd0);
        @(negedge clk);
        check("timeout_idle", 64'(busy), 64'd0);
        check("timeout_err", 64'(err), 64'd1);
        check("timeout_no_res_valid", 64'(resv_cnt - v0), 64'd0);

        // reset mid-stream with cnt=3
        start_frame(8);
        stream(8, 0, 3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ctrl", 64'({s_ready, acc_start, acc_sv, acc_last, res_valid, busy, err,
                                  frame_id, win_addr}), 64'd0);
        check("midrst_data", 64'({acc_i, acc_q, acc_window}), 64'd0);
        check("midrst_no_pending", 64'(exp_q.size()), 64'd0);
        rst = 1'b0;
        exp_fid = '0;
        @(negedge clk);

        // fresh N=2 frame after reset
        start_frame(2);
        stream(2, 0, 2);
        wait_drain();
        complete(2);
        check("post_reset_err", 64'(err), 64'd0);

        // zero-length frame
        s0 = start_cnt;
        frame_len = '0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_len_err", 64'(err), 64'd1);
        check("zero_len_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("zero_len_no_start", 64'(start_cnt - s0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
